// File: rtl/load_store_unit_if.sv
// Memory bus between the load/store unit (master) and the data memory (slave).
// One request/grant phase followed by a single response beat flagged by rvalid.
interface load_store_unit_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> REQ -> WAIT -> DONE, all outputs registered.
// Define MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of issuing them.
module load_store_unit (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       address_i,
  input  logic [31:0]       store_data_i,
  load_store_unit_if.master mem,
  output logic [31:0]       load_value_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              misaligned_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  state_t      state_reg, state_next;
  logic        req_reg, req_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [3:0]  be_reg, be_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] load_value_reg, load_value_next;
  logic        done_reg, done_next;
  logic        busy_reg, busy_next;
  logic        misaligned_reg, misaligned_next;
  logic        is_load_reg, is_load_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic [1:0]  offset_reg, offset_next;

  logic        accept;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        misalign_hit;
  logic [31:0] lane_data;
  logic [31:0] load_extracted;

  assign accept = (state_reg == ST_IDLE) && start_i && (is_load_i || is_store_i);

  // funct3[1:0] encodes size; 10 and 11 both fall through to word
  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        req_be    = 4'b0001 << address_i[1:0];
        req_wdata = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        req_be    = 4'b0011 << address_i[1:0];
        req_wdata = {2{store_data_i[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = store_data_i;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign_hit = ((funct3_i[1:0] == 2'b01) && address_i[0]) ||
                        (funct3_i[1] && (address_i[1:0] != 2'b00));
`else
  assign misalign_hit = 1'b0;
`endif

  assign lane_data = mem.mem_rdata_i >> {offset_reg, 3'b000};

  always_comb begin
    case (funct3_reg[1:0])
      2'b00:   load_extracted = funct3_reg[2] ? {24'd0, lane_data[7:0]}
                                              : {{24{lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_extracted = funct3_reg[2] ? {16'd0, lane_data[15:0]}
                                              : {{16{lane_data[15]}}, lane_data[15:0]};
      default: load_extracted = mem.mem_rdata_i;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    req_next        = 1'b0;
    done_next       = 1'b0;
    busy_next       = 1'b0;
    misaligned_next = 1'b0;
    we_next         = we_reg;
    addr_next       = addr_reg;
    be_next         = be_reg;
    wdata_next      = wdata_reg;
    load_value_next = load_value_reg;
    is_load_next    = is_load_reg;
    funct3_next     = funct3_reg;
    offset_next     = offset_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          busy_next = 1'b1;
          if (misalign_hit) begin
            // Fault without touching the bus; the pulse lands with done
            state_next      = ST_DONE;
            done_next       = 1'b1;
            misaligned_next = 1'b1;
          end else begin
            state_next   = ST_REQ;
            req_next     = 1'b1;
            we_next      = is_store_i && !is_load_i;
            addr_next    = {address_i[31:2], 2'b00};
            be_next      = req_be;
            wdata_next   = req_wdata;
            is_load_next = is_load_i;
            funct3_next  = funct3_i;
            offset_next  = address_i[1:0];
          end
        end
      end
      ST_REQ: begin
        busy_next = 1'b1;
        if (mem.mem_gnt_i) begin
          state_next = ST_WAIT;
        end else begin
          req_next = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem.mem_rvalid_i) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
          if (is_load_reg) begin
            load_value_next = load_extracted;
          end
        end else begin
          busy_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= ST_IDLE;
      req_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= 32'd0;
      be_reg         <= 4'd0;
      wdata_reg      <= 32'd0;
      load_value_reg <= 32'd0;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      misaligned_reg <= 1'b0;
      is_load_reg    <= 1'b0;
      funct3_reg     <= 3'd0;
      offset_reg     <= 2'd0;
    end else begin
      state_reg      <= state_next;
      req_reg        <= req_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      be_reg         <= be_next;
      wdata_reg      <= wdata_next;
      load_value_reg <= load_value_next;
      done_reg       <= done_next;
      busy_reg       <= busy_next;
      misaligned_reg <= misaligned_next;
      is_load_reg    <= is_load_next;
      funct3_reg     <= funct3_next;
      offset_reg     <= offset_next;
    end
  end

  assign mem.mem_req_o   = req_reg;
  assign mem.mem_we_o    = we_reg;
  assign mem.mem_addr_o  = addr_reg;
  assign mem.mem_be_o    = be_reg;
  assign mem.mem_wdata_o = wdata_reg;
  assign load_value_o    = load_value_reg;
  assign done_o          = done_reg;
  assign busy_o          = busy_reg;
  assign misaligned_o    = misaligned_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected load values are queued at start_i
// and popped when done_o pulses; bus fields and latency are checked inline.
module tb_load_store_unit;
  logic        clk;
  logic        rst_ni;
  logic        start_i;
  logic        is_load_i;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] address_i;
  logic [31:0] store_data_i;
  logic [31:0] load_value_o;
  logic        done_o;
  logic        busy_o;
  logic        misaligned_o;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load = 32'd0;

  load_store_unit_if mem_bus ();

  load_store_unit dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .is_load_i   (is_load_i),
    .is_store_i  (is_store_i),
    .funct3_i    (funct3_i),
    .address_i   (address_i),
    .store_data_i(store_data_i),
    .mem         (mem_bus),
    .load_value_o(load_value_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .misaligned_o(misaligned_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_ni = 1'b0;
    start_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
    funct3_i = 3'd0; address_i = 32'd0; store_data_i = 32'd0;
    mem_bus.mem_gnt_i = 1'b0; mem_bus.mem_rvalid_i = 1'b0; mem_bus.mem_rdata_i = 32'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_be_o, done_o, busy_o, misaligned_o} !== 9'd0 ||
        mem_bus.mem_addr_o !== 32'd0 || mem_bus.mem_wdata_o !== 32'd0 || load_value_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_values: req=%b we=%b be=%b addr=%h wdata=%h lv=%h done=%b busy=%b mis=%b, expected all 0",
               mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_be_o, mem_bus.mem_addr_o,
               mem_bus.mem_wdata_o, load_value_o, done_o, busy_o, misaligned_o);
    end
    rst_ni = 1'b1;
    // A late response arriving while idle must be ignored
    mem_bus.mem_rvalid_i = 1'b1; mem_bus.mem_rdata_i = 32'h1357_9BDF;
    @(negedge clk);
    mem_bus.mem_rvalid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || load_value_o !== 32'd0 || mem_bus.mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_rvalid: done=%b busy=%b lv=%h req=%b, expected 0 0 00000000 0",
               done_o, busy_o, load_value_o, mem_bus.mem_req_o);
    end
    $display("reset: outputs cleared, idle rvalid ignored");
  endtask

  task automatic do_op(input string name, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                       input int gnt_delay, input logic [3:0] exp_be, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_load);
    int cyc;
    int waited;
    logic exp_we;
    logic [31:0] exp_val;
    exp_we = st && !ld;
    @(negedge clk);
    start_i = 1'b1; is_load_i = ld; is_store_i = st; funct3_i = f3;
    address_i = addr; store_data_i = sdata;
    exp_q.push_back(exp_load);
    @(negedge clk);
    start_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
    address_i = 32'hFFFF_FFFF; store_data_i = 32'h0;
    cyc = 1;
    waited = 0;
    while (1) begin
      vectors++;
      if (mem_bus.mem_req_o !== 1'b1 || mem_bus.mem_addr_o !== exp_addr || mem_bus.mem_be_o !== exp_be ||
          mem_bus.mem_wdata_o !== exp_wdata || mem_bus.mem_we_o !== exp_we || busy_o !== 1'b1) begin
        miscompares++;
        $display("FAIL %s req cyc%0d: req=%b addr=%h be=%b wdata=%h we=%b busy=%b, expected 1 %h %b %h %b 1",
                 name, cyc, mem_bus.mem_req_o, mem_bus.mem_addr_o, mem_bus.mem_be_o,
                 mem_bus.mem_wdata_o, mem_bus.mem_we_o, busy_o, exp_addr, exp_be, exp_wdata, exp_we);
      end
      if (waited >= gnt_delay) begin
        mem_bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_bus.mem_gnt_i = 1'b0;
        cyc++;
        break;
      end
      waited++;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (mem_bus.mem_req_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s wait: req=%b busy=%b done=%b, expected 0 1 0", name, mem_bus.mem_req_o, busy_o, done_o);
    end
    mem_bus.mem_rvalid_i = 1'b1; mem_bus.mem_rdata_i = rdata;
    @(negedge clk);
    mem_bus.mem_rvalid_i = 1'b0; mem_bus.mem_rdata_i = 32'h0;
    cyc++;
    vectors++;
    if (done_o !== 1'b1 || misaligned_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done cyc%0d: done=%b mis=%b busy=%b, expected 1 0 0 at cycle %0d",
               name, cyc, done_o, misaligned_o, busy_o, 3 + gnt_delay);
    end
    exp_val = exp_q.pop_front();
    vectors++;
    if (load_value_o !== exp_val) begin
      miscompares++;
      $display("FAIL %s load_value: got %h, expected %h", name, load_value_o, exp_val);
    end
    @(negedge clk);
    vectors++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || mem_bus.mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_done: done=%b busy=%b req=%b, expected 0 0 0", name, done_o, busy_o, mem_bus.mem_req_o);
    end
    if (ld) last_load = exp_load;
    $display("%s: addr=%h be=%b wdata=%h load_value=%h", name, exp_addr, exp_be, exp_wdata, load_value_o);
  endtask

  task automatic test_loads();
    do_op("LW",  1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h100, 32'h0, 32'hDEAD_BEEF);
    do_op("LB",  1, 0, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 0, 4'b1000, 32'h100, 32'h0, 32'hFFFF_FF80);
    do_op("LBU", 1, 0, 3'b100, 32'h103, 32'h0, 32'h8011_2233, 0, 4'b1000, 32'h100, 32'h0, 32'h0000_0080);
    do_op("LH",  1, 0, 3'b001, 32'h102, 32'h0, 32'h8011_2233, 1, 4'b1100, 32'h100, 32'h0, 32'hFFFF_8011);
    do_op("LHU", 1, 0, 3'b101, 32'h102, 32'h0, 32'h8011_2233, 0, 4'b1100, 32'h100, 32'h0, 32'h0000_8011);
    do_op("LB0", 1, 0, 3'b000, 32'h0F0, 32'h0, 32'h0000_007F, 0, 4'b0001, 32'h0F0, 32'h0, 32'h0000_007F);
  endtask

  task automatic test_funct3_as_word();
    do_op("L011", 1, 0, 3'b011, 32'h104, 32'h0, 32'h1234_5678, 0, 4'b1111, 32'h104, 32'h0, 32'h1234_5678);
    do_op("L110", 1, 0, 3'b110, 32'h108, 32'h0, 32'h8765_4321, 1, 4'b1111, 32'h108, 32'h0, 32'h8765_4321);
  endtask

  task automatic test_stores();
    do_op("SH", 0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 3, 4'b1100, 32'h200, 32'hABCD_ABCD, last_load);
    do_op("SB", 0, 1, 3'b000, 32'h101, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 4'b0010, 32'h100, 32'hA5A5_A5A5, last_load);
    do_op("SW", 0, 1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'hFFFF_FFFF, 2, 4'b1111, 32'h300, 32'hCAFE_F00D, last_load);
  endtask

  task automatic test_misaligned();
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    start_i = 1'b1; is_load_i = 1'b1; funct3_i = 3'b010; address_i = 32'h102;
    @(negedge clk);
    start_i = 1'b0; is_load_i = 1'b0;
    vectors++;
    if (done_o !== 1'b1 || misaligned_o !== 1'b1 || mem_bus.mem_req_o !== 1'b0 || load_value_o !== last_load) begin
      miscompares++;
      $display("FAIL trap_lw: done=%b mis=%b req=%b lv=%h, expected 1 1 0 %h",
               done_o, misaligned_o, mem_bus.mem_req_o, load_value_o, last_load);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (done_o !== 1'b0 || misaligned_o !== 1'b0 || mem_bus.mem_req_o !== 1'b0) begin
        miscompares++;
        $display("FAIL trap_after%0d: done=%b mis=%b req=%b, expected 0 0 0",
                 i, done_o, misaligned_o, mem_bus.mem_req_o);
      end
    end
    $display("trap LW 0x102: done and misaligned pulsed, no request");
`else
    // Without trapping, a halfword at offset 3 keeps only byte lane 3
    do_op("LH_off3", 1, 0, 3'b001, 32'h103, 32'h0, 32'hAABB_CCDD, 0, 4'b1000, 32'h100, 32'h0, 32'h0000_00AA);
`endif
  endtask

  task automatic test_start_during_wait();
    int reqs;
    int dones;
    logic [31:0] exp_val;
    reqs = 0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_bus.mem_req_o === 1'b1) reqs++;
      if (done_o === 1'b1) begin
        dones++;
        exp_val = exp_q.pop_front();
        vectors++;
        if (i !== 4 || load_value_o !== exp_val) begin
          miscompares++;
          $display("FAIL busy_start done: at step %0d lv=%h, expected step 4 lv=%h", i, load_value_o, exp_val);
        end
      end
      start_i   = (i == 0) || (i == 2);
      is_load_i = (i == 0) || (i == 2);
      funct3_i  = 3'b010;
      address_i = (i == 0) ? 32'h500 : 32'h600;
      if (i == 0) exp_q.push_back(32'h0BAD_F00D);
      mem_bus.mem_gnt_i    = (i == 1);
      mem_bus.mem_rvalid_i = (i == 3);
      mem_bus.mem_rdata_i  = (i == 3) ? 32'h0BAD_F00D : 32'h0;
    end
    vectors++;
    if (reqs !== 1 || dones !== 1 || mem_bus.mem_addr_o !== 32'h500) begin
      miscompares++;
      $display("FAIL busy_start counts: reqs=%0d dones=%0d addr=%h, expected 1 1 00000500", reqs, dones, mem_bus.mem_addr_o);
    end
    last_load = 32'h0BAD_F00D;
    $display("start during WAIT: reqs=%0d dones=%0d", reqs, dones);
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    start_i = 1'b1; is_load_i = 1'b1; funct3_i = 3'b010; address_i = 32'h400;
    @(negedge clk);
    start_i = 1'b0; is_load_i = 1'b0;
    mem_bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_bus.mem_gnt_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b1 || mem_bus.mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wait pre: busy=%b req=%b, expected 1 0", busy_o, mem_bus.mem_req_o);
    end
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.mem_be_o, done_o, busy_o, misaligned_o} !== 9'd0 ||
        mem_bus.mem_addr_o !== 32'd0 || mem_bus.mem_wdata_o !== 32'd0 || load_value_o !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_wait async: req=%b addr=%h be=%b lv=%h done=%b busy=%b, expected all 0",
               mem_bus.mem_req_o, mem_bus.mem_addr_o, mem_bus.mem_be_o, load_value_o, done_o, busy_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    mem_bus.mem_rvalid_i = 1'b1; mem_bus.mem_rdata_i = 32'h5555_5555;
    @(negedge clk);
    mem_bus.mem_rvalid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || mem_bus.mem_req_o !== 1'b0 || load_value_o !== 32'd0) begin
        miscompares++;
        $display("FAIL rst_wait after%0d: done=%b busy=%b req=%b lv=%h, expected 0 0 0 00000000",
                 i, done_o, busy_o, mem_bus.mem_req_o, load_value_o);
      end
      @(negedge clk);
    end
    last_load = 32'd0;
    $display("reset during WAIT: transaction dropped, late rvalid ignored");
  endtask

  initial begin
    test_reset();
    test_loads();
    test_funct3_as_word();
    test_stores();
    test_misaligned();
    test_start_during_wait();
    test_reset_mid_wait();
    do_op("LW_post", 1, 0, 3'b010, 32'h700, 32'h0, 32'h0F0F_0F0F, 0, 4'b1111, 32'h700, 32'h0, 32'h0F0F_0F0F);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk_i input 1, rising-edge clock; rst_ni input 1, async active-low reset.
REQ-002 SHALL have ports start_i in 1 (one-cycle pulse: execute has a valid memory op), is_load_i in 1, is_store_i in 1, funct3_i in 3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-003 SHALL have ports address_i in 32 (effective address from execute), store_data_i in 32 (rs2 value).
REQ-004 SHALL have bus ports mem_req_o out 1, mem_we_o out 1, mem_addr_o out 32 (word-aligned), mem_be_o out 4, mem_wdata_o out 32, mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in 32.
REQ-005 SHALL have core-side ports load_value_o out 32, done_o out 1 (one-cycle completion pulse), busy_o out 1 (stall request), misaligned_o out 1 (fault pulse).

Function
REQ-006 SHALL implement FSM IDLE -> REQ -> WAIT -> DONE -> IDLE; all outputs registered.
REQ-007 IDLE: start_i with is_load_i or is_store_i SHALL latch the op and go to REQ next cycle; start_i with neither flag set SHALL be ignored.
REQ-008 REQ: mem_req_o=1 with addr/we/be/wdata held constant until the first cycle mem_gnt_i=1, then go to WAIT.
REQ-009 WAIT: mem_req_o=0; the first cycle with mem_rvalid_i=1 SHALL capture data (loads) or acknowledge the write (stores), then go to DONE.
REQ-010 mem_rvalid_i outside WAIT SHALL be ignored; bus rule: rvalid never arrives in the same cycle as gnt.
REQ-011 DONE: done_o=1 for exactly one cycle, then IDLE; load_value_o SHALL hold until the next load completes.
REQ-012 Minimum latency: start_i at cycle 0, gnt at 1, rvalid at 2, giving done_o at cycle 3.
REQ-013 busy_o SHALL be 1 in REQ and WAIT and on the cycle after an accepted start_i; start_i while not IDLE SHALL be ignored.
REQ-014 mem_addr_o = {address_i[31:2], 2'b00}.
REQ-015 Byte enables: B/BU give 4'b0001 << addr[1:0]; H/HU give 4'b0011 << addr[1:0]; W gives 4'b1111.
REQ-016 Store data: byte ops replicate byte [7:0] to all 4 lanes; halfword ops replicate [15:0] to both halves; mem_we_o=1 for stores only.
REQ-017 Load extraction: select lane by addr[1:0]; B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-018 Funct3 values 011, 110, 111 SHALL be treated as W.

Reset
REQ-019 Asserting rst_ni low SHALL immediately force IDLE, even mid-transaction (REQ or WAIT).
REQ-020 Reset values: mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, load_value_o=0, done_o=0, busy_o=0, misaligned_o=0.
REQ-021 After reset release, a late mem_rvalid_i SHALL be ignored in IDLE.

Configuration
REQ-022 Macro MISALIGN_TRAP_EN SHALL control misaligned-access handling.
REQ-023 Defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, SHALL NOT issue a bus request; the FSM goes IDLE -> DONE; done_o and misaligned_o pulse together on the cycle after start_i; load_value_o is unchanged.
REQ-024 Undefined: no misalignment checking; misaligned_o is tied 0; address low bits are applied per REQ-015/017, and byte enables shifted past bit 3 are truncated.

Verification
REQ-025 LW: address 0x100, gnt cycle 1, rvalid cycle 2, rdata 0xDEADBEEF -> mem_be 1111, done_o at cycle 3, load_value_o 0xDEADBEEF.
REQ-026 LB: address 0x103, rdata 0x80112233 -> be 1000, load_value_o 0xFFFFFF80; same stimulus with LBU -> 0x00000080.
REQ-027 SH: address 0x202, data 0x1234ABCD, gnt held low 3 cycles -> req held 4 cycles with stable addr 0x200, be 1100, wdata 0xABCDABCD, we=1.
REQ-028 rst_ni pulsed low during WAIT, then rvalid=1 -> no done_o, all outputs at reset values, busy_o=0.
REQ-029 With MISALIGN_TRAP_EN, LW at address 0x102 -> mem_req_o never asserted, done_o=misaligned_o=1 at cycle 1.
REQ-030 start_i pulsed again during WAIT -> ignored; exactly one bus request and one done_o pulse.
